instr_sequencer: RTL
====================

// Module: instr_sequencer
// PURPOSE
//  Multi-cycle fetch/decode/sequence controller for single_cycle_datapath. Owns the 64-bit PC.
//  Fetches each instruction over a req/valid handshake and decodes it into datapath control strobes for one EXEC cycle.
//  Resolves B, CBZ and B.LT, and halts on an unsupported opcode.
// PARAMETERS
//  RESET_PC  64'h0  PC value loaded on reset
// PORTS
//  clk          in   1   clock; all state updates on posedge
//  reset        in   1   asynchronous, active-high reset
//  imem_req     out  1   fetch request, held high in FETCH
//  imem_addr    out  64  fetch address, always equal to pc
//  imem_valid   in   1   imem_rdata valid this cycle (only sampled while imem_req=1)
//  imem_rdata   in   32  fetched instruction word
//  instruction  out  32  latched instruction driven to the datapath
//  Reg2Loc, RegWrite, MemWrite, MemToReg, ALUSrc, RightShift, weFlags  out  1 each  datapath controls
//  ALUOp        out  3   ALU control: 000 pass-B, 010 add, 011 sub, 110 xor
//  zero         in   1   combinational ALU zero, used by CBZ in EXEC
//  negative, overflow  in  1  latched datapath flags, used by B.LT
//  pc           out  64  current PC
//  halted       out  1   high once in HALT
// BEHAVIOUR
//  Reset (async): state=FETCH, pc=RESET_PC, instruction=0, halted=0; all control outputs 0.
//  Controls are combinational from state+instruction and are 0 in every state except EXEC.
//  FETCH:
//   - imem_req=1.
//   - On imem_valid=1: latch instruction<=imem_rdata and go to EXEC.
//   - Otherwise stay in FETCH; there is no timeout.
//  EXEC: exactly one cycle, then FETCH. Best case is 2 cycles per instruction.
//  Decode in EXEC (R=Reg2Loc W=RegWrite M=MemWrite T=MemToReg S=ALUSrc H=RightShift F=weFlags):
//   ADDI  [31:22]=1001000100   W S, ALUOp=010
//   ADDS  [31:21]=10101011000  R W F, 010
//   SUBS  [31:21]=11101011000  R W F, 011
//   EOR   [31:21]=11001010000  R W, 110
//   LDUR  [31:21]=11111000010  W T S, 010
//   STUR  [31:21]=11111000000  M S, 010
//   LSR   [31:21]=11010011010  W H
//   B     [31:26]=000101       all controls 0
//   CBZ   [31:24]=10110100     ALUOp=000, Reg2Loc=0 (Rt on read port B)
//   B.LT  [31:24]=01010100, [4:0]=01011   all controls 0
//  PC update at end of EXEC:
//   - B: pc += sext(instr[25:0])<<2.
//   - CBZ with zero=1, or B.LT with negative!=overflow: pc += sext(instr[23:5])<<2.
//   - Otherwise pc += 4.
//   - Arithmetic is modulo 2^64; wrap-around is allowed silently.
//  Any other encoding, including B.cond with a cond other than LT:
//   - No controls asserted; go to HALT with pc unchanged; halted=1.
//  HALT: absorbing; imem_req=0, all controls 0; only reset exits.
//  Branch to self (offset 0) is legal and loops forever with no hang detection.
//  Reset asserted mid-fetch or mid-EXEC: state and pc go to reset values immediately.
//   The in-flight imem response is ignored, and the datapath sees no partial write because RegWrite/MemWrite drop at once.
//  imem_valid arriving outside FETCH is ignored.
// TESTING
//  T1 reset: reset=1 then 0 -> pc=0, imem_req=1, all controls 0, halted=0.
//  T2 ADDI X0,X31,#1 (0x910007E0) with valid after 3 wait cycles:
//     imem_req high 4 cycles; then one EXEC cycle with RegWrite=1 ALUSrc=1 ALUOp=010; pc=4.
//  T3 program ADDI, ADDS, EOR, STUR, LSR, LDUR, SUBS (each valid on 1st cycle):
//     X6=-2 read back via the datapath; weFlags pulses only on ADDS/SUBS; pc=28.
//  T4 CBZ X31,#+4 (0xB400009F) at pc=8, zero=1 -> pc=24.
//     Same word with zero=0 -> pc=12.
//  T5 B.LT #-2 at pc=16: with negative=1 overflow=0 -> pc=8; with negative=1 overflow=1 -> pc=20.
//     B #-1 (0x17FFFFFF) at pc=0 -> pc=64'hFFFF_FFFF_FFFF_FFFC (wrap).
//  T6 fetch 32'h0 -> halted=1, pc unchanged, imem_req=0 forever.
//     Reset asserted during EXEC of STUR -> MemWrite drops in the same cycle, pc=0.

Source files
------------

// File: rtl/instr_sequencer.sv
// Fetch/decode/sequence controller: fetches over a req/valid handshake, drives datapath
// control strobes for one EXEC cycle per instruction, and resolves B, CBZ and B.LT.
module instr_sequencer #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic        Reg2Loc,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        MemToReg,
    output logic        ALUSrc,
    output logic        RightShift,
    output logic        weFlags,
    output logic [2:0]  ALUOp,
    input  logic        zero,
    input  logic        negative,
    input  logic        overflow,
    output logic [63:0] pc,
    output logic        halted
);

    typedef enum logic [1:0] {StFetch, StExec, StHalt} state_e;

    state_e      state;
    logic        dec_legal;
    logic        dec_b;
    logic        dec_cbz;
    logic        dec_blt;
    logic [9:0]  dec_ctrl;  // {R, W, M, T, S, H, F, ALUOp[2:0]}
    logic [63:0] br_off;
    logic [63:0] cond_off;
    logic [63:0] pc_next;
    logic        exec;

    always_comb begin
        dec_legal = 1'b1;
        dec_b     = 1'b0;
        dec_cbz   = 1'b0;
        dec_blt   = 1'b0;
        dec_ctrl  = '0;
        if (instruction[31:22] == 10'b1001000100) begin
            dec_ctrl = 10'b0100100_010;                   // ADDI
        end else if (instruction[31:21] == 11'b10101011000) begin
            dec_ctrl = 10'b1100001_010;                   // ADDS
        end else if (instruction[31:21] == 11'b11101011000) begin
            dec_ctrl = 10'b1100001_011;                   // SUBS
        end else if (instruction[31:21] == 11'b11001010000) begin
            dec_ctrl = 10'b1100000_110;                   // EOR
        end else if (instruction[31:21] == 11'b11111000010) begin
            dec_ctrl = 10'b0101100_010;                   // LDUR
        end else if (instruction[31:21] == 11'b11111000000) begin
            dec_ctrl = 10'b0010100_010;                   // STUR
        end else if (instruction[31:21] == 11'b11010011010) begin
            dec_ctrl = 10'b0100010_000;                   // LSR
        end else if (instruction[31:26] == 6'b000101) begin
            dec_b = 1'b1;
        end else if (instruction[31:24] == 8'b10110100) begin
            dec_cbz = 1'b1;
        end else if (instruction[31:24] == 8'b01010100 && instruction[4:0] == 5'b01011) begin
            dec_blt = 1'b1;
        end else begin
            dec_legal = 1'b0;
        end
    end

    assign br_off   = {{36{instruction[25]}}, instruction[25:0], 2'b00};
    assign cond_off = {{43{instruction[23]}}, instruction[23:5], 2'b00};

    always_comb begin
        if (dec_b) begin
            pc_next = pc + br_off;
        end else if ((dec_cbz && zero) || (dec_blt && (negative != overflow))) begin
            pc_next = pc + cond_off;
        end else begin
            pc_next = pc + 64'd4;
        end
    end

    // Strobes are combinational so a reset during EXEC drops them immediately.
    assign exec = (state == StExec);

    always_comb begin
        Reg2Loc    = exec & dec_ctrl[9];
        RegWrite   = exec & dec_ctrl[8];
        MemWrite   = exec & dec_ctrl[7];
        MemToReg   = exec & dec_ctrl[6];
        ALUSrc     = exec & dec_ctrl[5];
        RightShift = exec & dec_ctrl[4];
        weFlags    = exec & dec_ctrl[3];
        ALUOp      = exec ? dec_ctrl[2:0] : 3'b000;
    end

    assign imem_req  = (state == StFetch);
    assign imem_addr = pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= StFetch;
            pc          <= RESET_PC;
            instruction <= 32'h0;
            halted      <= 1'b0;
        end else begin
            case (state)
                StFetch: begin
                    if (imem_valid) begin
                        instruction <= imem_rdata;
                        state       <= StExec;
                    end
                end
                StExec: begin
                    if (dec_legal) begin
                        pc    <= pc_next;
                        state <= StFetch;
                    end else begin
                        state  <= StHalt;
                        halted <= 1'b1;
                    end
                end
                default: begin
                    state <= StHalt;
                end
            endcase
        end
    end

endmodule
